alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 36 +++
 rtl/alu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Instruction/result bus of the sequential ALU.
// master = instruction source and result consumer, slave = the ALU itself.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in;
   logic [3:0]       inst;
   logic             inst_valid;
   logic             busy;
   logic [WIDTH-1:0] RET;
   logic             ret_valid;
   logic             carry;
   logic             zero;

   modport master (
      output in,
      output inst,
      output inst_valid,
      input  busy,
      input  RET,
      input  ret_valid,
      input  carry,
      input  zero
   );

   modport slave (
      input  in,
      input  inst,
      input  inst_valid,
      output busy,
      output RET,
      output ret_valid,
      output carry,
      output zero
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential accumulator-style ALU with two operand registers (A, B),
// single-cycle logic/arithmetic ops and an optional shift-add multiplier
// that takes WIDTH cycles and holds off new instructions while running.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input logic      clock,
   input logic      reset,
   alu_seq_if.slave bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_LDB  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_MOVA = 4'hB;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_MUL_RUN = 1'b1
   } state_t;

   typedef struct packed {
      logic             en;
      logic             cy;
      logic [WIDTH-1:0] res;
   } alu_out_t;

   // Single-cycle operation result; en=0 for opcodes that produce no result
   // in one cycle (NOP, loads, MUL, reserved codes).
   function automatic alu_out_t alu_eval(input logic [3:0]       op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
      alu_out_t       o;
      logic [WIDTH:0] sum;
      logic [WIDTH:0] diff;
      o    = '0;
      sum  = {1'b0, a} + {1'b0, b};
      // The extra top bit of an unsigned subtraction is the borrow (a < b).
      diff = {1'b0, a} - {1'b0, b};
      o.en = 1'b1;
      case (op)
         OP_ADD:  begin o.res = sum[WIDTH-1:0];  o.cy = sum[WIDTH];  end
         OP_SUB:  begin o.res = diff[WIDTH-1:0]; o.cy = diff[WIDTH]; end
         OP_AND:  o.res = a & b;
         OP_OR:   o.res = a | b;
         OP_XOR:  o.res = a ^ b;
         OP_SHL:  begin o.res = {a[WIDTH-2:0], 1'b0}; o.cy = a[WIDTH-1]; end
         OP_SHR:  begin o.res = {1'b0, a[WIDTH-1:1]}; o.cy = a[0];       end
         OP_MOVA: o.res = a;
         default: o.en = 1'b0;
      endcase
      return o;
   endfunction

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   ret_reg;
   logic               carry_reg;
   logic               zero_reg;
   logic               ret_valid_reg;

   // Multiplier working set: shifting multiplicand, consumed multiplier
   // bits, partial-product accumulator and step counter.
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic               mul_start;
   logic               mul_last;
   logic [2*WIDTH-1:0] prod_nxt;
   alu_out_t           alu_o;

   assign bus.busy      = (state == S_MUL_RUN);
   assign bus.RET       = ret_reg;
   assign bus.ret_valid = ret_valid_reg;
   assign bus.carry     = carry_reg;
   assign bus.zero      = zero_reg;

   // Partial product including the current multiplier bit; on the last
   // step this is the complete product.
   always_comb begin
      prod_nxt = acc + (mplier[0] ? mcand : '0);
      alu_o    = alu_eval(bus.inst, a_reg, b_reg);
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // FSM next state plus accept/start/finish strobes for the datapath.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      mul_start = 1'b0;
      mul_last  = 1'b0;
      case (state)
         S_IDLE: begin
            accept = bus.inst_valid;
            if (accept && MUL_EN && (bus.inst == OP_MUL)) begin
               mul_start = 1'b1;
               state_nxt = S_MUL_RUN;
            end
         end
         S_MUL_RUN: begin
            mul_last = (cnt == CNT_LAST);
            if (mul_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand registers, result/flags and the shift-add multiplier steps.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_reg         <= '0;
         b_reg         <= '0;
         ret_reg       <= '0;
         carry_reg     <= 1'b0;
         zero_reg      <= 1'b0;
         ret_valid_reg <= 1'b0;
         mcand         <= '0;
         mplier        <= '0;
         acc           <= '0;
         cnt           <= '0;
      end else begin
         ret_valid_reg <= 1'b0;
         if (state == S_MUL_RUN) begin
            acc    <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
               ret_reg       <= prod_nxt[WIDTH-1:0];
               carry_reg     <= |prod_nxt[2*WIDTH-1:WIDTH];
               zero_reg      <= (prod_nxt[WIDTH-1:0] == '0);
               ret_valid_reg <= 1'b1;
            end
         end else if (accept) begin
            if (bus.inst == OP_LDA) a_reg <= bus.in;
            if (bus.inst == OP_LDB) b_reg <= bus.in;
            if (mul_start) begin
               // Snapshot operands so A/B stay architecturally untouched.
               mcand  <= {{WIDTH{1'b0}}, a_reg};
               mplier <= b_reg;
               acc    <= '0;
               cnt    <= '0;
            end
            if (alu_o.en) begin
               ret_reg       <= alu_o.res;
               carry_reg     <= alu_o.cy;
               zero_reg      <= (alu_o.res == '0);
               ret_valid_reg <= 1'b1;
            end
         end
      end
   end

endmodule
